// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing generator.
// A clock divider produces the pixel strobe. Column and line counters walk the
// raster. Sync and blanking flags are registered from the next counter values,
// so they always line up with HCount/VCount.
module vga_sync_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic [9:0] HCount,
   output logic [9:0] VCount,
   output logic       HSync,
   output logic       VSync,
   output logic       video_on,
   output logic       pixel_tick,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   // Sync windows are [start, end): end is the first column/line past the pulse.
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [2:0] div;
   logic       h_wrap, v_wrap;
   logic [9:0] h_next, v_next;

   // Pixel divider: counts 0..CLK_DIV-1 while enabled and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div <= 3'd0;
      else if (enable)
         div <= (div == DIV_LAST) ? 3'd0 : div + 3'd1;
   end

   // Strobes and next raster position. Compare against the last value
   // instead of relying on counter overflow.
   always_comb begin
      pixel_tick = enable && (div == DIV_LAST);
      h_wrap     = (HCount == H_LAST);
      v_wrap     = (VCount == V_LAST);
      frame_tick = pixel_tick && h_wrap && v_wrap;
      h_next     = HCount;
      v_next     = VCount;
      if (pixel_tick) begin
         h_next = h_wrap ? 10'd0 : HCount + 10'd1;
         if (h_wrap)
            v_next = v_wrap ? 10'd0 : VCount + 10'd1;
      end
   end

   // Raster counters, decoded flags and frame counter. Reset parks the beam
   // on the last pixel of the vertical back porch, so the first tick starts
   // a fresh frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HCount      <= H_LAST;
         VCount      <= V_LAST;
         HSync       <= 1'b1;
         VSync       <= 1'b1;
         video_on    <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         HCount      <= h_next;
         VCount      <= v_next;
         HSync       <= !((h_next >= HS_START) && (h_next < HS_END));
         VSync       <= !((v_next >= VS_START) && (v_next < VS_END));
         video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
         if (frame_tick)
            frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three instances share clock, reset and enable.
//   u_a: CLK_DIV=2 with a tiny 16x8 raster, so many frames fit in a short run.
//   u_b: CLK_DIV=1 with the same tiny raster, used for frame_count wrap.
//   u_c: the default 640x480 timing at CLK_DIV=2, used for line-level behaviour.
// Reference model: count the enabled clock edges since reset. The pixel index
// and the raster position then follow from plain division and modulo.
module tb_vga_sync_gen;

   localparam int THV = 8, THF = 2, THS = 3, THB = 3;
   localparam int TVV = 4, TVF = 1, TVS = 2, TVB = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;

   logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
   logic       a_hs, a_vs, a_von, a_pt, a_ft;
   logic       b_hs, b_vs, b_von, b_pt, b_ft;
   logic       c_hs, c_vs, c_von, c_pt, c_ft;
   logic [7:0] a_fc, b_fc, c_fc;

   int     n_chk = 0;
   int     n_err = 0;
   longint e = 0;   // enabled clk edges since last reset release

   always #5 clk = ~clk;

   vga_sync_gen #(.CLK_DIV(2), .H_VISIBLE(THV), .H_FP(THF), .H_SYNC(THS), .H_BP(THB),
                  .V_VISIBLE(TVV), .V_FP(TVF), .V_SYNC(TVS), .V_BP(TVB)) u_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .HCount(a_h), .VCount(a_v),
      .HSync(a_hs), .VSync(a_vs), .video_on(a_von), .pixel_tick(a_pt),
      .frame_tick(a_ft), .frame_count(a_fc));

   vga_sync_gen #(.CLK_DIV(1), .H_VISIBLE(THV), .H_FP(THF), .H_SYNC(THS), .H_BP(THB),
                  .V_VISIBLE(TVV), .V_FP(TVF), .V_SYNC(TVS), .V_BP(TVB)) u_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .HCount(b_h), .VCount(b_v),
      .HSync(b_hs), .VSync(b_vs), .video_on(b_von), .pixel_tick(b_pt),
      .frame_tick(b_ft), .frame_count(b_fc));

   vga_sync_gen u_c (
      .clk(clk), .rst_n(rst_n), .enable(enable), .HCount(c_h), .VCount(c_v),
      .HSync(c_hs), .VSync(c_vs), .video_on(c_von), .pixel_tick(c_pt),
      .frame_tick(c_ft), .frame_count(c_fc));

   // Expected output vector {h, v, hsync, vsync, video_on, pixel_tick, frame_tick, frame_count}.
   function automatic logic [32:0] ref_out(int cd, int hv, int hf, int hs, int hb,
                                           int vv, int vf, int vs, int vb,
                                           longint ec, logic en);
      longint ht, vt, tot, p, l, fc;
      int     h, v;
      logic   hsy, vsy, von, pt, ft;
      ht  = hv + hf + hs + hb;
      vt  = vv + vf + vs + vb;
      tot = ht * vt;
      p   = ec / cd;                  // pixel ticks already taken
      l   = (tot - 1 + p) % tot;      // linear position, starting on the last pixel
      h   = int'(l % ht);
      v   = int'(l / ht);
      fc  = ((p + tot - 1) / tot) % 256;
      hsy = !(h >= hv + hf && h < hv + hf + hs);
      vsy = !(v >= vv + vf && v < vv + vf + vs);
      von = (h < hv) && (v < vv);
      pt  = en && ((ec % cd) == cd - 1);
      ft  = pt && (l == tot - 1);
      return {10'(h), 10'(v), hsy, vsy, von, pt, ft, 8'(fc)};
   endfunction

   function automatic logic [32:0] exp_a(longint ec, logic en);
      return ref_out(2, THV, THF, THS, THB, TVV, TVF, TVS, TVB, ec, en);
   endfunction
   function automatic logic [32:0] exp_b(longint ec, logic en);
      return ref_out(1, THV, THF, THS, THB, TVV, TVF, TVS, TVB, ec, en);
   endfunction
   function automatic logic [32:0] exp_c(longint ec, logic en);
      return ref_out(2, 640, 16, 96, 48, 480, 10, 2, 33, ec, en);
   endfunction

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model state: advance on every enabled edge; clear asynchronously on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         e <= 0;
      else if (enable)
         e <= e + 1;
   end

   // Full-output comparison of every instance on every falling edge.
   always @(negedge clk) begin
      chk("a_out", {a_h, a_v, a_hs, a_vs, a_von, a_pt, a_ft, a_fc}, exp_a(e, enable));
      chk("b_out", {b_h, b_v, b_hs, b_vs, b_von, b_pt, b_ft, b_fc}, exp_b(e, enable));
      chk("c_out", {c_h, c_v, c_hs, c_vs, c_von, c_pt, c_ft, c_fc}, exp_c(e, enable));
   end

   // Assert reset between edges and check all outputs before the next edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_a"}, {a_h, a_v, a_hs, a_vs, a_von, a_pt, a_ft, a_fc}, exp_a(0, enable));
      chk({tag, "_b"}, {b_h, b_v, b_hs, b_vs, b_von, b_pt, b_ft, b_fc}, exp_b(0, enable));
      chk({tag, "_c"}, {c_h, c_v, c_hs, c_vs, c_von}, {10'd799, 10'd524, 1'b1, 1'b1, 1'b0});
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bit     found;
      bit     seen_wrap;
      logic [7:0] prev_fc;
      longint a_last, b_last;
      bit     a_done, b_done;

      // Reset release, then the first tick on clk 2 at CLK_DIV=2.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("a_first_tick", {a_pt, a_ft}, 2'b11);
      @(negedge clk);
      chk("a_frame_start", {a_h, a_v, a_von, a_hs, a_vs, a_fc},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd1});
      chk("c_frame_start", {c_h, c_v, c_von, c_hs, c_vs, c_fc},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd1});

      // Enable gating at HCount=300, mid-pixel with div=1.
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (c_h == 10'd300 && c_pt) found = 1'b1;
      end
      chk("c_reach_300", found, 1'b1);
      #2 enable = 1'b0;
      repeat (37) begin
         @(negedge clk);
         chk("c_hold", {c_h, c_v, c_hs, c_von, c_pt, c_ft}, {10'd300, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
      end
      #2 enable = 1'b1;
      #1 chk("c_resume_tick", c_pt, 1'b1);
      @(negedge clk);
      chk("c_resume_h", c_h, 10'd301);

      // Asynchronous reset mid-line at HCount=400.
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (c_h == 10'd400) found = 1'b1;
      end
      chk("c_reach_400", found, 1'b1);
      async_reset("rst400");

      // Random enable pattern with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1 enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 499) == 0) async_reset("rst_rand");
      end

      // Free run: frame period and frame_count wrap on the CLK_DIV=1 instance.
      @(posedge clk);
      #1 enable = 1'b1;
      seen_wrap = 1'b0;
      a_done = 1'b0;
      b_done = 1'b0;
      a_last = -1;
      b_last = -1;
      @(negedge clk);
      prev_fc = b_fc;
      for (longint cyc = 0; cyc < 33500; cyc++) begin
         @(negedge clk);
         if (prev_fc == 8'd255 && b_fc == 8'd0) seen_wrap = 1'b1;
         prev_fc = b_fc;
         if (a_ft) begin
            if (a_last >= 0 && !a_done) begin
               chk("a_frame_period", 33'(cyc - a_last), 33'd256);
               a_done = 1'b1;
            end
            a_last = cyc;
         end
         if (b_ft) begin
            if (b_last >= 0 && !b_done) begin
               chk("b_frame_period", 33'(cyc - b_last), 33'd128);
               b_done = 1'b1;
            end
            b_last = cyc;
         end
      end
      chk("a_period_seen", a_done, 1'b1);
      chk("b_period_seen", b_done, 1'b1);
      chk("b_fc_wrap", seen_wrap, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
